dds_sweep_ctrl: RTL
===================

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter PW, default 32, meaning width of step, phase and duty words.
REQ-002 The block SHALL have parameter DW, default 24, meaning width of the dwell counter.
REQ-003 Ports SHALL be exactly as follows (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; sampled in IDLE only.
- abort  in  1  terminate the sweep in progress.
- loop  in  1  0 = one-shot sweep, 1 = restart from start_step after reaching stop_step.
- start_step  in  PW  first frequency control word.
- stop_step  in  PW  final frequency control word.
- delta_step  in  PW  unsigned increment per step.
- dwell  in  DW  cycles each step value is held (0 treated as 1).
- duty_in  in  PW  duty threshold for the whole sweep.
- phase_in  in  PW  phase offset for the whole sweep.
- step_out  out  PW  frequency control word to the PWM/DDS generator.
- phase_out  out  PW  phase offset to the generator.
- duty_out  out  PW  duty threshold to the generator.
- gen_reset_n  out  1  active-low accumulator reset to the generator.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-004 The FSM SHALL have states IDLE, ALIGN, DWELL, DONE; all outputs SHALL be registered.
REQ-005 In IDLE with start=1 and abort=0, the block SHALL latch start_step, stop_step, delta_step, dwell, loop, duty_in and phase_in; load step_out=start_step, phase_out=phase_in, duty_out=duty_in; and enter ALIGN.
REQ-006 Configuration inputs SHALL be ignored outside the IDLE start cycle; start while busy=1 SHALL be ignored.
REQ-007 ALIGN SHALL last exactly one cycle with gen_reset_n=0, load the dwell counter with max(dwell,1), and enter DWELL; gen_reset_n SHALL be 1 in all other states.
REQ-008 DWELL SHALL decrement the counter each cycle; each step_out value SHALL be presented for exactly max(dwell,1) cycles.
REQ-009 Direction SHALL be up when latched stop_step >= start_step, otherwise down.
REQ-010 At counter expiry with step_out != stop_step, the next value SHALL be step_out +/- delta_step, computed at PW+1 bits and clamped to stop_step if it passes stop_step or overflows/underflows; the counter SHALL reload.
REQ-011 delta_step = 0 SHALL jump step_out to stop_step at the first expiry.
REQ-012 At counter expiry with step_out == stop_step: if loop=1, step_out SHALL reload start_step, the counter SHALL reload, and the state SHALL remain DWELL (no ALIGN, no done); if loop=0, the state SHALL go to DONE.
REQ-013 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; step_out SHALL keep stop_step.
REQ-014 abort=1 in ALIGN, DWELL or DONE SHALL force IDLE on the next edge, with no done pulse, gen_reset_n=1, and step_out/phase_out/duty_out holding their current values; abort SHALL have priority over expiry and start.
REQ-015 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-016 start_step == stop_step SHALL hold for one dwell period, then enter DONE (or repeat when loop=1).

Reset
REQ-017 When reset=1, the block SHALL asynchronously set state=IDLE; step_out, phase_out, duty_out and the counter to 0; busy=0; done=0; gen_reset_n=1.
REQ-018 Reset asserted mid-sweep SHALL abandon the sweep immediately; after release the block SHALL wait for a new start.

Verification
REQ-019 Up sweep: start=10, stop=40, delta=10, dwell=3, loop=0 -> gen_reset_n low 1 cycle; step_out 10,20,30,40 each for 3 cycles; done pulse 1 cycle; busy low afterwards.
REQ-020 Clamp and down sweep: start=100, stop=75, delta=10, dwell=1 -> step_out 100,90,80,75; then done. Overflow case: start=0xFFFFFFF0, stop=0xFFFFFFFF, delta=0x20 -> step_out jumps to 0xFFFFFFFF.
REQ-021 Loop: start=1, stop=3, delta=1, dwell=2, loop=1 -> step_out 1,1,2,2,3,3,1,1,...; done never asserted; abort -> busy low next cycle, step_out holds its value.
REQ-022 Edge cases: dwell=0 -> 1 cycle per step; delta=0 with start=5, stop=9 -> 5 then 9, then done; start==stop=7 -> one dwell period, then done.
REQ-023 Protocol: start pulses while busy and config changes mid-sweep -> no effect on the sequence; start+abort together in IDLE -> stays IDLE.
REQ-024 Reset asserted asynchronously mid-DWELL, between clock edges -> outputs zero immediately; after release, no activity until start.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for a PWM/DDS generator: steps a frequency
// control word from start_step toward stop_step, holding each value for a
// programmable dwell, with one-shot or looping operation and abort.
module dds_sweep_ctrl #(
   parameter int unsigned PW = 32,
   parameter int unsigned DW = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          loop,
   input  logic [PW-1:0] start_step,
   input  logic [PW-1:0] stop_step,
   input  logic [PW-1:0] delta_step,
   input  logic [DW-1:0] dwell,
   input  logic [PW-1:0] duty_in,
   input  logic [PW-1:0] phase_in,
   output logic [PW-1:0] step_out,
   output logic [PW-1:0] phase_out,
   output logic [PW-1:0] duty_out,
   output logic          gen_reset_n,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIGN = 2'd1,
      S_DWELL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q;
   logic [PW-1:0] step_q, phase_q, duty_q;
   logic [PW-1:0] start_step_q, stop_step_q, delta_q;
   logic [DW-1:0] dwell_q, cnt_q;
   logic          loop_q, up_q;
   logic          gen_rst_n_q, busy_q, done_q;

   logic [PW:0]   sum_w, diff_w;
   logic [PW-1:0] next_step_d;
   logic [DW-1:0] dwell_eff_w;

   // A zero dwell behaves as a one-cycle dwell.
   assign dwell_eff_w = (dwell == '0) ? DW'(1) : dwell;

   // Candidate steps are formed one bit wider so overflow/underflow show in the MSB.
   assign sum_w  = {1'b0, step_q} + {1'b0, delta_q};
   assign diff_w = {1'b0, step_q} - {1'b0, delta_q};

   // Next step value, clamped to stop_step on overshoot, wrap or zero delta.
   always_comb begin
      next_step_d = stop_step_q;
      if (delta_q != '0) begin
         if (up_q) begin
            if (!sum_w[PW] && (sum_w[PW-1:0] < stop_step_q))
               next_step_d = sum_w[PW-1:0];
         end else begin
            if (!diff_w[PW] && (diff_w[PW-1:0] > stop_step_q))
               next_step_d = diff_w[PW-1:0];
         end
      end
   end

   // Sweep FSM with registered outputs; abort takes priority over everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         step_q       <= '0;
         phase_q      <= '0;
         duty_q       <= '0;
         cnt_q        <= '0;
         start_step_q <= '0;
         stop_step_q  <= '0;
         delta_q      <= '0;
         dwell_q      <= DW'(1);
         loop_q       <= 1'b0;
         up_q         <= 1'b1;
         gen_rst_n_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q      <= 1'b0;
               gen_rst_n_q <= 1'b1;
               if (start && !abort) begin
                  start_step_q <= start_step;
                  stop_step_q  <= stop_step;
                  delta_q      <= delta_step;
                  dwell_q      <= dwell_eff_w;
                  loop_q       <= loop;
                  up_q         <= (stop_step >= start_step);
                  step_q       <= start_step;
                  phase_q      <= phase_in;
                  duty_q       <= duty_in;
                  gen_rst_n_q  <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (abort) begin
                  gen_rst_n_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end else begin
                  cnt_q       <= dwell_q;
                  gen_rst_n_q <= 1'b1;
                  state_q     <= S_DWELL;
               end
            end
            S_DWELL: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q == DW'(1)) begin
                  if (step_q == stop_step_q) begin
                     if (loop_q) begin
                        step_q <= start_step_q;
                        cnt_q  <= dwell_q;
                     end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end
                  end else begin
                     step_q <= next_step_d;
                     cnt_q  <= dwell_q;
                  end
               end else begin
                  cnt_q <= cnt_q - DW'(1);
               end
            end
            S_DONE: begin
               // done is high for exactly the one cycle spent here.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               gen_rst_n_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign step_out    = step_q;
   assign phase_out   = phase_q;
   assign duty_out    = duty_q;
   assign gen_reset_n = gen_rst_n_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
